// File: rtl/dbg_bus_master_pkg.sv
// Shared constants for the debug bus master: address width,
// host command opcodes and response codes.
package dbg_bus_master_pkg;

    localparam int ADDR_WIDTH = 16;

    localparam logic [7:0] OP_WRITE_W = 8'h57;
    localparam logic [7:0] OP_WRITE_B = 8'h42;
    localparam logic [7:0] OP_READ_W  = 8'h52;
    localparam logic [7:0] RSP_ACK    = 8'h06;
    localparam logic [7:0] RSP_NAK    = 8'h15;

    typedef enum logic [1:0] {
        CMD_W,
        CMD_B,
        CMD_R
    } cmd_e;

endpackage

// File: rtl/dbg_bus_master_if.sv
// UART byte streams plus the arbitrated dmem bus of the debug master.
interface dbg_bus_master_if #(
    parameter int AW = dbg_bus_master_pkg::ADDR_WIDTH
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          bus_req;
    logic          bus_gnt;
    logic [AW-1:0] dmem_addr;
    logic          dmem_wen;
    logic          dmem_byt;
    logic [15:0]   dmem_wdata;
    logic [15:0]   dmem_rdata;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_gnt, dmem_rdata,
        output tx_data, tx_valid, bus_req,
        output dmem_addr, dmem_wen, dmem_byt, dmem_wdata
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_gnt, dmem_rdata,
        input  tx_data, tx_valid, bus_req,
        input  dmem_addr, dmem_wen, dmem_byt, dmem_wdata
    );

endinterface

// File: rtl/dbg_byte_timeout.sv
// Inter-byte watchdog: reloaded on each accepted byte, counts down
// while enabled and flags expiry when it reaches zero.
module dbg_byte_timeout #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(CYCLES - 1);
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/dbg_bus_master.sv
// Host-driven debug initiator: parses UART commands, performs one
// dmem access once granted and answers with data or ACK/NAK.
module dbg_bus_master #(
    parameter int ADDR_WIDTH     = dbg_bus_master_pkg::ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    dbg_bus_master_if.master   bus,
    output logic               overrun
);

    import dbg_bus_master_pkg::*;

    typedef enum logic [3:0] {
        IDLE,
        ARGS,
        REQ,
        WRITE,
        RD_ADDR,
        RD_DATA,
        TX_HI,
        TX_LO,
        TX_CODE
    } state_e;

    state_e      state;
    cmd_e        cmd;
    logic [2:0]  cnt;
    logic [31:0] args;
    logic [31:0] shifted;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic [15:0] fin_addr;
    logic [15:0] fin_data;
    logic        collecting;
    logic        tmo_exp;

    assign collecting = (state == IDLE) || (state == ARGS);
    assign shifted    = {args[23:0], bus.rx_data};

    // Operand split as seen once the final argument byte is shifted in
    always_comb begin
        fin_addr = shifted[15:0];
        fin_data = 16'h0000;
        unique case (1'b1)
            cmd == CMD_W: begin
                fin_addr = shifted[31:16];
                fin_data = shifted[15:0];
            end
            cmd == CMD_B: begin
                fin_addr = shifted[23:8];
                fin_data = {8'h00, shifted[7:0]};
            end
            default: ;
        endcase
    end

    dbg_byte_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (bus.rx_valid && collecting),
        .en      (state == ARGS),
        .expired (tmo_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cmd            <= CMD_R;
            cnt            <= '0;
            args           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            overrun        <= 1'b0;
            bus.tx_data    <= '0;
            bus.tx_valid   <= 1'b0;
            bus.bus_req    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wen   <= 1'b0;
            bus.dmem_byt   <= 1'b0;
            bus.dmem_wdata <= '0;
        end else begin
            if (bus.rx_valid && !collecting) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        args <= '0;
                        unique case (1'b1)
                            bus.rx_data == OP_WRITE_W: begin
                                cmd   <= CMD_W;
                                cnt   <= 3'd4;
                                state <= ARGS;
                            end
                            bus.rx_data == OP_WRITE_B: begin
                                cmd   <= CMD_B;
                                cnt   <= 3'd3;
                                state <= ARGS;
                            end
                            bus.rx_data == OP_READ_W: begin
                                cmd   <= CMD_R;
                                cnt   <= 3'd2;
                                state <= ARGS;
                            end
                            default: begin
                                bus.tx_data  <= RSP_NAK;
                                bus.tx_valid <= 1'b1;
                                state        <= TX_CODE;
                            end
                        endcase
                    end
                end
                ARGS: begin
                    if (bus.rx_valid) begin
                        args <= shifted;
                        cnt  <= cnt - 3'd1;
                        if (cnt == 3'd1) begin
                            // Odd word-write addresses are refused outright
                            if (cmd == CMD_W && fin_addr[0]) begin
                                bus.tx_data  <= RSP_NAK;
                                bus.tx_valid <= 1'b1;
                                state        <= TX_CODE;
                            end else begin
                                addr_q      <= fin_addr;
                                wdata_q     <= fin_data;
                                bus.bus_req <= 1'b1;
                                state       <= REQ;
                            end
                        end
                    end else if (tmo_exp) begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (bus.bus_gnt) begin
                        bus.dmem_addr <= addr_q[ADDR_WIDTH-1:0];
                        if (cmd == CMD_R) begin
                            state <= RD_ADDR;
                        end else begin
                            bus.dmem_wen   <= 1'b1;
                            bus.dmem_byt   <= (cmd == CMD_B);
                            bus.dmem_wdata <= wdata_q;
                            state          <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    bus.bus_req    <= 1'b0;
                    bus.dmem_addr  <= '0;
                    bus.dmem_wen   <= 1'b0;
                    bus.dmem_byt   <= 1'b0;
                    bus.dmem_wdata <= '0;
                    bus.tx_data    <= RSP_ACK;
                    bus.tx_valid   <= 1'b1;
                    state          <= TX_CODE;
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    rdata_q       <= bus.dmem_rdata;
                    bus.bus_req   <= 1'b0;
                    bus.dmem_addr <= '0;
                    bus.tx_data   <= bus.dmem_rdata[15:8];
                    bus.tx_valid  <= 1'b1;
                    state         <= TX_HI;
                end
                TX_HI: begin
                    if (bus.tx_ready) begin
                        bus.tx_data <= rdata_q[7:0];
                        state       <= TX_LO;
                    end
                end
                TX_LO, TX_CODE: begin
                    if (bus.tx_ready) begin
                        bus.tx_data  <= '0;
                        bus.tx_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_bus_master.sv
// Scoreboard bench for dbg_bus_master: expected writes and tx bytes
// are queued at stimulus time and retired by negedge monitors.
module tb_dbg_bus_master;

    localparam int TO = 50;

    typedef struct packed {
        logic [15:0] addr;
        logic        byt;
        logic [15:0] wdata;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic overrun;
    int   n_chk = 0;
    int   n_err = 0;

    logic [7:0] exp_tx[$];
    wr_t        exp_wr[$];

    dbg_bus_master_if #(.AW(16)) bus ();

    dbg_bus_master #(
        .ADDR_WIDTH     (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_model(input logic [15:0] a);
        return (a == 16'h0100) ? 16'hBEEF : {a[7:0], ~a[7:0]};
    endfunction

    // Registered memory: data valid the cycle after the address
    always @(posedge clk) bus.dmem_rdata <= rd_model(bus.dmem_addr);

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    logic [7:0] held;
    logic       held_v = 1'b0;
    wr_t        w;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_valid) begin
                if (held_v) chk("tx_hold", {24'd0, bus.tx_data}, {24'd0, held});
                if (bus.tx_ready) begin
                    if (exp_tx.size() == 0) chk("tx_unexp", exp_tx.size(), 1);
                    else chk("tx", {24'd0, bus.tx_data}, {24'd0, exp_tx.pop_front()});
                    held_v = 1'b0;
                end else begin
                    held   = bus.tx_data;
                    held_v = 1'b1;
                end
            end else begin
                held_v = 1'b0;
            end
            if (bus.dmem_wen) begin
                if (exp_wr.size() == 0) begin
                    chk("wen_unexp", exp_wr.size(), 1);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", {16'd0, bus.dmem_addr}, {16'd0, w.addr});
                    chk("wr_byt", {31'd0, bus.dmem_byt}, {31'd0, w.byt});
                    chk("wr_data", {16'd0, bus.dmem_wdata}, {16'd0, w.wdata});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic exp_write(input logic [15:0] a, input logic b,
                             input logic [15:0] d);
        exp_wr.push_back({a, b, d});
        exp_tx.push_back(8'h06);
    endtask

    task automatic exp_read(input logic [15:0] a);
        logic [15:0] d;
        d = rd_model(a);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[7:0]);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 || bus.tx_valid)
               && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, exp_tx.size() + exp_wr.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        bus.bus_gnt  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", {23'd0, bus.tx_valid, bus.tx_data}, 0);
        chk("rst_bus", {14'd0, bus.bus_req, bus.dmem_wen, bus.dmem_addr}, 0);
        chk("rst_wd", {15'd0, bus.dmem_byt, bus.dmem_wdata}, 0);
        chk("rst_ovr", {31'd0, overrun}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Word write, with latency of wen
        exp_write(16'h0082, 1'b0, 16'h1234);
        send(8'h57); send(8'h00); send(8'h82); send(8'h12); send(8'h34);
        chk("w_lat1", {31'd0, bus.dmem_wen}, 0);
        @(negedge clk);
        chk("w_lat2", {31'd0, bus.dmem_wen}, 1);
        drain("drain_w");

        exp_write(16'h0080, 1'b1, 16'h00A5);
        send(8'h42); send(8'h00); send(8'h80); send(8'hA5);
        drain("drain_b");

        // Read with tx back-pressure
        bus.tx_ready = 1'b0;
        exp_read(16'h0100);
        send(8'h52); send(8'h01); send(8'h00);
        @(negedge clk);
        chk("r_addr", {16'd0, bus.dmem_addr}, 32'h0100);
        chk("r_wen", {31'd0, bus.dmem_wen}, 0);
        repeat (2) @(negedge clk);
        chk("r_txv", {31'd0, bus.tx_valid}, 1);
        chk("r_hi", {24'd0, bus.tx_data}, 32'hBE);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 bus.tx_ready = 1'b1;
        drain("drain_r");

        exp_tx.push_back(8'h15);
        send(8'h57); send(8'h00); send(8'h81); send(8'h00); send(8'h01);
        drain("drain_odd");
        exp_tx.push_back(8'h15);
        send(8'h00);
        drain("drain_bad");

        // Grant withheld after the arguments
        bus.bus_gnt = 1'b0;
        exp_write(16'h0084, 1'b0, 16'hABCD);
        send(8'h57); send(8'h00); send(8'h84); send(8'hAB); send(8'hCD);
        repeat (20) begin
            @(negedge clk);
            chk("gnt_wait", {14'd0, bus.bus_req, bus.dmem_wen, bus.dmem_addr},
                {14'd0, 1'b1, 1'b0, 16'h0000});
        end
        bus.bus_gnt = 1'b1;
        @(negedge clk);
        chk("gnt_wen", {31'd0, bus.dmem_wen}, 1);
        drain("drain_gnt");

        // Inter-byte timeout then a normal read
        send(8'h52); send(8'h00);
        repeat (60) @(negedge clk);
        chk("to_req", {31'd0, bus.bus_req}, 0);
        exp_read(16'h0080);
        send(8'h52); send(8'h00); send(8'h80);
        drain("drain_to");

        // Byte injected during transmit
        bus.tx_ready = 1'b0;
        exp_tx.push_back(8'h15);
        send(8'h00);
        chk("ovr0", {31'd0, overrun}, 0);
        send(8'h57);
        chk("ovr1", {31'd0, overrun}, 1);
        @(posedge clk);
        #2 bus.tx_ready = 1'b1;
        drain("drain_ovr");
        exp_read(16'h0082);
        send(8'h52); send(8'h00); send(8'h82);
        drain("drain_post");

        // Reset mid-command
        send(8'h57); send(8'h00);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_ovr", {31'd0, overrun}, 0);
        chk("mid_req", {31'd0, bus.bus_req}, 0);
        rst_n = 1'b1;
        exp_write(16'h0090, 1'b1, 16'h005A);
        send(8'h42); send(8'h00); send(8'h90); send(8'h5A);
        drain("drain_mid");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
